// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: shares one AXI4 SRAM read port between NUM_MASTER requesters
// (master 0 = IFU, master 1 = LSU). One outstanding burst at a time; the grant
// is held from address accept until the rlast beat is consumed.
// Optional feature macro: AXI_ARB_RR_EN (round-robin). Without it the lowest
// requesting index wins (fixed priority).
module axi4_rd_arbiter #(
   parameter int NUM_MASTER = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                             i_aclk,
   input  logic                             i_arst,
   input  logic [NUM_MASTER-1:0]            i_m_arvalid,
   output logic [NUM_MASTER-1:0]            o_m_arready,
   input  logic [NUM_MASTER*ADDR_WIDTH-1:0] i_m_araddr,
   input  logic [NUM_MASTER*8-1:0]          i_m_arlen,
   input  logic [NUM_MASTER*2-1:0]          i_m_arsize,
   output logic [NUM_MASTER-1:0]            o_m_rvalid,
   input  logic [NUM_MASTER-1:0]            i_m_rready,
   output logic [DATA_WIDTH-1:0]            o_m_rdata,
   output logic [1:0]                       o_m_rresp,
   output logic                             o_m_rlast,
   output logic [3:0]                       o_s_arid,
   output logic [ADDR_WIDTH-1:0]            o_s_araddr,
   output logic [7:0]                       o_s_arlen,
   output logic [1:0]                       o_s_arsize,
   output logic                             o_s_arvalid,
   input  logic                             i_s_arready,
   input  logic [3:0]                       i_s_rid,
   input  logic [DATA_WIDTH-1:0]            i_s_rdata,
   input  logic [1:0]                       i_s_rresp,
   input  logic                             i_s_rlast,
   input  logic                             i_s_rvalid,
   output logic                             o_s_rready
);

   localparam int GW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                state, state_nxt;
   logic [GW-1:0]         g;         // granted master, held for the whole burst
   logic [GW-1:0]         w;         // arbitration winner this cycle
   logic                  any_req;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [1:0]            size_q;

   // No handshake is offered while reset is held, so nothing is accepted
   // that the reset would immediately discard.
   assign accept = (state == IDLE) && any_req && !i_arst;

`ifdef AXI_ARB_RR_EN
   logic [GW-1:0] p;
   logic          last_fire;

   assign last_fire = (state == DATA) && i_s_rvalid && i_m_rready[g] && i_s_rlast;

   // Round-robin: scan downward over offsets from p so the smallest offset wins.
   always_comb begin
      int idx;
      idx     = 0;
      w       = '0;
      any_req = 1'b0;
      for (int i = NUM_MASTER - 1; i >= 0; i--) begin
         idx = int'(p) + i;
         if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
         if (i_m_arvalid[idx]) begin
            w       = GW'(idx);
            any_req = 1'b1;
         end
      end
   end

   // Pointer moves past the master whose burst just completed.
   always_ff @(posedge i_aclk) begin
      if (i_arst)
         p <= '0;
      else if (last_fire)
         p <= (g == GW'(NUM_MASTER - 1)) ? '0 : g + 1'b1;
   end
`else
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      w       = '0;
      any_req = 1'b0;
      for (int i = NUM_MASTER - 1; i >= 0; i--) begin
         if (i_m_arvalid[i]) begin
            w       = GW'(i);
            any_req = 1'b1;
         end
      end
   end
`endif

   // State register.
   always_ff @(posedge i_aclk) begin
      if (i_arst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Capture the winner's request on the accept cycle; held stable through ADDR.
   always_ff @(posedge i_aclk) begin
      if (i_arst) begin
         g      <= '0;
         addr_q <= '0;
         len_q  <= '0;
         size_q <= '0;
      end else if (accept) begin
         g      <= w;
         addr_q <= i_m_araddr[int'(w)*ADDR_WIDTH +: ADDR_WIDTH];
         len_q  <= i_m_arlen[int'(w)*8 +: 8];
         size_q <= i_m_arsize[int'(w)*2 +: 2];
      end
   end

   // Next state and handshake routing.
   always_comb begin
      state_nxt   = state;
      o_m_arready = '0;
      o_s_arvalid = 1'b0;
      o_m_rvalid  = '0;
      o_s_rready  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               o_m_arready[w] = 1'b1;
               state_nxt      = ADDR;
            end
         end
         ADDR: begin
            o_s_arvalid = 1'b1;
            if (i_s_arready) state_nxt = DATA;
         end
         DATA: begin
            o_m_rvalid[g] = i_s_rvalid;
            o_s_rready    = i_m_rready[g];
            if (i_s_rvalid && i_m_rready[g] && i_s_rlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_s_arid   = 4'(g);
   assign o_s_araddr = addr_q;
   assign o_s_arlen  = len_q;
   assign o_s_arsize = size_q;
   assign o_m_rdata  = i_s_rdata;
   assign o_m_rresp  = i_s_rresp;
   assign o_m_rlast  = i_s_rlast;

`ifndef SYNTHESIS
   // Read data carrying another id is still routed to the granted master;
   // flag it in simulation so a misbehaving slave is noticed.
   always_ff @(posedge i_aclk) begin
      if (!i_arst && state == DATA && i_s_rvalid && i_s_rid != 4'(g))
         $display("axi4_rd_arbiter: rid %0d differs from grant %0d", i_s_rid, g);
   end
`endif

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter (2 masters, 32-bit addr, 64-bit data).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_axi4_rd_arbiter;
   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 64;
`ifdef AXI_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
   logic [N*AW-1:0] m_araddr;
   logic [N*8-1:0]  m_arlen;
   logic [N*2-1:0]  m_arsize;
   logic [DW-1:0]   m_rdata, s_rdata;
   logic [1:0]      m_rresp, s_rresp, s_arsize;
   logic            m_rlast, s_rlast, s_rvalid, s_rready, s_arvalid, s_arready;
   logic [3:0]      s_arid, s_rid;
   logic [AW-1:0]   s_araddr;
   logic [7:0]      s_arlen;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi4_rd_arbiter #(.NUM_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_aclk(clk), .i_arst(rst),
      .i_m_arvalid(m_arvalid), .o_m_arready(m_arready), .i_m_araddr(m_araddr),
      .i_m_arlen(m_arlen), .i_m_arsize(m_arsize),
      .o_m_rvalid(m_rvalid), .i_m_rready(m_rready), .o_m_rdata(m_rdata),
      .o_m_rresp(m_rresp), .o_m_rlast(m_rlast),
      .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen), .o_s_arsize(s_arsize),
      .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
      .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
      .i_s_rvalid(s_rvalid), .o_s_rready(s_rready)
   );

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic set_m(input int k, input logic [AW-1:0] addr, input logic [7:0] len);
      m_araddr[k*AW +: AW] = addr;
      m_arlen[k*8 +: 8]    = len;
      m_arsize[k*2 +: 2]   = 2'd3;
   endtask

   // Slave side of one transaction starting in ADDR: accept address, send beats.
   task automatic serve(input int nbeats, input logic [3:0] rid);
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         s_rvalid = 1'b1;
         s_rid    = rid;
         s_rdata  = 64'hA000_0000_0000_0000 + 64'(b);
         s_rlast  = (b == nbeats - 1);
         m_rready = '1;
         step();
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      m_rready = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      m_arvalid = 2'b11;
      s_rvalid  = 1'b1;
      rst       = 1'b1;
      step();
      step();
      settle();
      checks++; if (m_arready !== 2'b00) begin failures++; $display("FAIL reset_arready got=%b exp=00", m_arready); end
      checks++; if (s_arvalid !== 1'b0) begin failures++; $display("FAIL reset_s_arvalid got=%b exp=0", s_arvalid); end
      checks++; if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin failures++; $display("FAIL reset_r got=%b/%b exp=00/0", m_rvalid, s_rready); end
      checks++; if (s_arid !== 4'd0 || s_araddr !== 32'd0 || s_arlen !== 8'd0) begin failures++; $display("FAIL reset_ar got=%h/%h/%h exp=0/0/0", s_arid, s_araddr, s_arlen); end
      m_arvalid = '0;
      s_rvalid  = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_ifu();
      set_m(0, 32'h8000_0000, 8'd0);
      m_arvalid = 2'b01;
      settle();
      checks++; if (m_arready !== 2'b01 || s_arvalid !== 1'b0) begin failures++; $display("FAIL single_grant got=%b/%b exp=01/0", m_arready, s_arvalid); end
      step();
      m_arvalid = 2'b00;
      settle();
      checks++; if (s_arvalid !== 1'b1 || s_arid !== 4'd0 || s_araddr !== 32'h8000_0000 || s_arlen !== 8'd0 || s_arsize !== 2'd3)
         begin failures++; $display("FAIL single_ar got=%b/%h/%h/%h exp=1/0/80000000/00", s_arvalid, s_arid, s_araddr, s_arlen); end
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rdata   = 64'h1122_3344_5566_7788;
      s_rlast   = 1'b1;
      s_rid     = 4'd0;
      m_rready  = 2'b01;
      settle();
      checks++; if (m_rvalid !== 2'b01 || s_rready !== 1'b1) begin failures++; $display("FAIL single_rroute got=%b/%b exp=01/1", m_rvalid, s_rready); end
      checks++; if (m_rdata !== 64'h1122_3344_5566_7788 || m_rlast !== 1'b1) begin failures++; $display("FAIL single_rdata got=%h/%b exp=1122334455667788/1", m_rdata, m_rlast); end
      step();
      settle();
      checks++; if (m_rvalid !== 2'b00 || s_rready !== 1'b0 || s_arvalid !== 1'b0) begin failures++; $display("FAIL single_idle got=%b/%b/%b exp=00/0/0", m_rvalid, s_rready, s_arvalid); end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      m_rready = '0;
   endtask

   task automatic test_arbitration();
      logic [1:0] exp1;
      do_reset();
      set_m(0, 32'h8000_0000, 8'd0);
      set_m(1, 32'h8000_1000, 8'd0);
      m_arvalid = 2'b11;
      settle();
      checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL arb_first got=%b exp=01", m_arready); end
      step();
      m_arvalid = 2'b10;
      settle();
      checks++; if (s_arid !== 4'd0 || s_araddr !== 32'h8000_0000 || m_arready !== 2'b00) begin failures++; $display("FAIL arb_first_ar got=%h/%h/%b exp=0/80000000/00", s_arid, s_araddr, m_arready); end
      serve(1, 4'd0);
      m_arvalid = 2'b11;
      exp1 = RR ? 2'b10 : 2'b01;
      settle();
      checks++; if (m_arready !== exp1) begin failures++; $display("FAIL arb_second got=%b exp=%b", m_arready, exp1); end
      step();
      m_arvalid = 2'b11 & ~exp1;
      settle();
      checks++; if (s_arid !== (RR ? 4'd1 : 4'd0)) begin failures++; $display("FAIL arb_second_id got=%h exp=%h", s_arid, RR ? 4'd1 : 4'd0); end
      serve(1, RR ? 4'd1 : 4'd0);
      settle();
      checks++; if (m_arready !== ~exp1) begin failures++; $display("FAIL arb_third got=%b exp=%b", m_arready, ~exp1); end
      step();
      m_arvalid = 2'b00;
      settle();
      checks++; if (s_arid !== (RR ? 4'd0 : 4'd1)) begin failures++; $display("FAIL arb_third_id got=%h exp=%h", s_arid, RR ? 4'd0 : 4'd1); end
      serve(1, RR ? 4'd0 : 4'd1);
   endtask

   task automatic test_burst();
      logic [4:0]  pat;
      logic [63:0] exp_data;
      int          beat;
      pat  = 5'b11101;   // m1 rready per cycle: 1,0,1,1,1
      beat = 0;
      set_m(1, 32'h8000_2000, 8'd3);
      m_arvalid = 2'b10;
      settle();
      checks++; if (m_arready !== 2'b10) begin failures++; $display("FAIL burst_grant got=%b exp=10", m_arready); end
      step();
      m_arvalid = 2'b00;
      settle();
      checks++; if (s_arlen !== 8'd3 || s_arid !== 4'd1 || s_araddr !== 32'h8000_2000) begin failures++; $display("FAIL burst_ar got=%h/%h/%h exp=03/1/80002000", s_arlen, s_arid, s_araddr); end
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         exp_data = 64'hB000_0000_0000_0000 + 64'(beat);
         s_rvalid = 1'b1;
         s_rid    = 4'd1;
         s_rdata  = exp_data;
         s_rlast  = (beat == 3);
         m_rready = {pat[c], 1'b1};
         settle();
         checks++; if (s_rready !== pat[c] || m_rvalid !== 2'b10) begin failures++; $display("FAIL burst_route c=%0d got=%b/%b exp=%b/10", c, s_rready, m_rvalid, pat[c]); end
         checks++; if (m_rdata !== exp_data || m_rlast !== (beat == 3)) begin failures++; $display("FAIL burst_data c=%0d got=%h/%b exp=%h/%b", c, m_rdata, m_rlast, exp_data, beat == 3); end
         if (pat[c]) beat++;
         step();
      end
      settle();
      checks++; if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin failures++; $display("FAIL burst_done got=%b/%b exp=00/0", m_rvalid, s_rready); end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      m_rready = '0;
   endtask

   task automatic test_addr_stall();
      set_m(0, 32'h8000_3000, 8'd0);
      m_arvalid = 2'b01;
      settle();
      checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL stall_grant got=%b exp=01", m_arready); end
      step();
      set_m(0, 32'h8000_4000, 8'd0);
      s_arready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         settle();
         checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_3000 || m_arready !== 2'b00)
            begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h/%b exp=1/80003000/00", c, s_arvalid, s_araddr, m_arready); end
         step();
      end
      serve(1, 4'd0);
      settle();
      checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL stall_regrant got=%b exp=01", m_arready); end
      step();
      m_arvalid = 2'b00;
      settle();
      checks++; if (s_araddr !== 32'h8000_4000) begin failures++; $display("FAIL stall_addr2 got=%h exp=80004000", s_araddr); end
      serve(1, 4'd0);
   endtask

   task automatic test_reset_mid();
      set_m(0, 32'h8000_5000, 8'd3);
      m_arvalid = 2'b01;
      settle();
      step();
      m_arvalid = 2'b00;
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         s_rvalid = 1'b1;
         s_rid    = 4'd0;
         s_rlast  = 1'b0;
         m_rready = 2'b01;
         step();
      end
      rst = 1'b1;
      settle();
      checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL rstmid_beat2 got=%b exp=01", m_rvalid); end
      step();
      settle();
      checks++; if (m_rvalid !== 2'b00 || s_rready !== 1'b0 || s_arvalid !== 1'b0 || m_arready !== 2'b00)
         begin failures++; $display("FAIL rstmid_idle got=%b/%b/%b/%b exp=00/0/0/00", m_rvalid, s_rready, s_arvalid, m_arready); end
      rst      = 1'b0;
      s_rvalid = 1'b0;
      m_rready = '0;
      step();
      set_m(0, 32'h8000_6000, 8'd0);
      m_arvalid = 2'b01;
      settle();
      checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL rstmid_fresh got=%b exp=01", m_arready); end
      step();
      m_arvalid = 2'b00;
      settle();
      checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_6000) begin failures++; $display("FAIL rstmid_ar got=%b/%h exp=1/80006000", s_arvalid, s_araddr); end
      serve(1, 4'd0);
   endtask

   task automatic test_rid_mismatch();
      set_m(1, 32'h8000_7000, 8'd0);
      m_arvalid = 2'b10;
      settle();
      step();
      m_arvalid = 2'b00;
      s_arready = 1'b1;
      step();
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rid     = 4'd0;
      s_rlast   = 1'b1;
      m_rready  = 2'b10;
      settle();
      checks++; if (m_rvalid !== 2'b10 || s_rready !== 1'b1) begin failures++; $display("FAIL rid_route got=%b/%b exp=10/1", m_rvalid, s_rready); end
      step();
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      m_rready = '0;
   endtask

   initial begin
      rst       = 1'b1;
      m_arvalid = '0;
      m_araddr  = '0;
      m_arlen   = '0;
      m_arsize  = '0;
      m_rready  = '0;
      s_arready = 1'b0;
      s_rid     = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rlast   = 1'b0;
      s_rvalid  = 1'b0;
      test_reset();
      test_single_ifu();
      test_arbitration();
      test_burst();
      test_addr_stall();
      test_reset_mid();
      test_rid_mismatch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
